// File: rtl/sram_arbiter.sv
// Two-requester controller for one asynchronous SRAM. It serves IF reads and MEM reads/writes
// with programmable strobe length, write recovery, latched read data and one-cycle acks.
module sram_arbiter #(
  parameter int ADDR_W   = 18,
  parameter int DATA_W   = 16,
  parameter int WAIT_CYC = 1,
  parameter int FAIR     = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  output logic              if_stall,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_ack,
  output logic              mem_stall,
  output logic [ADDR_W-1:0] sram_addr,
  inout  wire  [DATA_W-1:0] sram_data,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic              sram_en_n
);

  typedef enum logic [1:0] {IDLE, RD, WR, WR_REC} state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              gnt_mem_q, gnt_mem_d;
  logic              last_mem_q, last_mem_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              en_n_q, en_n_d;
  logic              oe_n_q, oe_n_d;
  logic              we_n_q, we_n_d;
  logic              drive_q, drive_d;
  logic              if_ack_q, if_ack_d;
  logic              mem_ack_q, mem_ack_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;

  logic if_pend;
  logic mem_pend;
  logic pick_mem;

  // A requester whose ack is high this cycle is completing, so its still-high req is not a new access.
  assign if_pend  = if_req & ~if_ack_q;
  assign mem_pend = mem_req & ~mem_ack_q;
  assign pick_mem = mem_pend & (~if_pend | (FAIR == 0) | ~last_mem_q);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    gnt_mem_d   = gnt_mem_q;
    last_mem_d  = last_mem_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    en_n_d      = en_n_q;
    oe_n_d      = oe_n_q;
    we_n_d      = we_n_q;
    drive_d     = drive_q;
    if_ack_d    = 1'b0;
    mem_ack_d   = 1'b0;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;

    case (state_q)
      IDLE: begin
        if (if_pend || mem_pend) begin
          gnt_mem_d  = pick_mem;
          last_mem_d = pick_mem;
          cnt_d      = 4'(WAIT_CYC);
          en_n_d     = 1'b0;
          if (pick_mem) begin
            addr_d  = mem_addr;
            wdata_d = mem_wdata;
            if (mem_we) begin
              state_d = WR;
              we_n_d  = 1'b0;
              drive_d = 1'b1;
            end else begin
              state_d = RD;
              oe_n_d  = 1'b0;
            end
          end else begin
            addr_d  = if_addr;
            state_d = RD;
            oe_n_d  = 1'b0;
          end
        end
      end
      RD: begin
        if (cnt_q == 4'd0) begin
          state_d = IDLE;
          en_n_d  = 1'b1;
          oe_n_d  = 1'b1;
          if (gnt_mem_q) begin
            mem_rdata_d = sram_data;
            mem_ack_d   = 1'b1;
          end else begin
            if_rdata_d = sram_data;
            if_ack_d   = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      WR: begin
        if (cnt_q == 4'd0) begin
          state_d = WR_REC;
          we_n_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      WR_REC: begin
        // Address and data stay on the bus one cycle past the WE rising edge for hold time.
        state_d   = IDLE;
        en_n_d    = 1'b1;
        drive_d   = 1'b0;
        mem_ack_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      gnt_mem_q   <= 1'b0;
      last_mem_q  <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      en_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      drive_q     <= 1'b0;
      if_ack_q    <= 1'b0;
      mem_ack_q   <= 1'b0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      gnt_mem_q   <= gnt_mem_d;
      last_mem_q  <= last_mem_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      en_n_q      <= en_n_d;
      oe_n_q      <= oe_n_d;
      we_n_q      <= we_n_d;
      drive_q     <= drive_d;
      if_ack_q    <= if_ack_d;
      mem_ack_q   <= mem_ack_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end

  assign sram_data = drive_q ? wdata_q : {DATA_W{1'bz}};
  assign sram_addr = addr_q;
  assign sram_en_n = en_n_q;
  assign sram_oe_n = oe_n_q;
  assign sram_we_n = we_n_q;
  assign if_ack    = if_ack_q;
  assign mem_ack   = mem_ack_q;
  assign if_rdata  = if_rdata_q;
  assign mem_rdata = mem_rdata_q;
  assign if_stall  = if_req & ~if_ack_q;
  assign mem_stall = mem_req & ~mem_ack_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: three instances (WAIT_CYC=1/FAIR=0, WAIT_CYC=1/FAIR=1, WAIT_CYC=0/FAIR=0)
// share one 64-word SRAM model; sel routes requests to one instance at a time.
module tb_sram_arbiter;
  localparam int AW = 18;
  localparam int DW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int sel;
  logic if_req, mem_req, mem_we;
  logic [AW-1:0] if_addr, mem_addr;
  logic [DW-1:0] mem_wdata;

  logic [DW-1:0] ifRdata [3];
  logic [DW-1:0] memRdata [3];
  logic ifAck [3];
  logic ifStall [3];
  logic memAck [3];
  logic memStall [3];
  logic [AW-1:0] sAddr [3];
  logic oeN [3];
  logic weN [3];
  logic enN [3];
  logic [DW-1:0] busObs [3];

  logic [DW-1:0] smem [64];
  logic [DW-1:0] refMem [64];
  logic plEn;
  logic [5:0] plAddr;
  logic [DW-1:0] plData;
  logic lastMem [3];

  int total = 0;
  int bad = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    wire [DW-1:0] sdata;
    sram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYC(g == 2 ? 0 : 1), .FAIR(g == 1 ? 1 : 0)) u_dut (
      .clk(clk), .rst(rst),
      .if_req(if_req && (sel == g)), .if_addr(if_addr), .if_rdata(ifRdata[g]),
      .if_ack(ifAck[g]), .if_stall(ifStall[g]),
      .mem_req(mem_req && (sel == g)), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(memRdata[g]), .mem_ack(memAck[g]), .mem_stall(memStall[g]),
      .sram_addr(sAddr[g]), .sram_data(sdata), .sram_oe_n(oeN[g]), .sram_we_n(weN[g]),
      .sram_en_n(enN[g]));
    assign sdata = (!enN[g] && !oeN[g]) ? smem[sAddr[g][5:0]] : {DW{1'bz}};
    assign busObs[g] = sdata;
  end

  // SRAM device: stores while CE and WE are both low.
  always @(posedge clk) begin
    if (plEn) smem[plAddr] <= plData;
    for (int k = 0; k < 3; k++)
      if (!enN[k] && !weN[k]) smem[sAddr[k][5:0]] <= busObs[k];
  end

  function automatic int waitOf(input int k);
    return (k == 2) ? 0 : 1;
  endfunction

  function automatic bit fairOf(input int k);
    return k == 1;
  endfunction

  task automatic doReset();
    if_req = 0; mem_req = 0;
    rst = 1;
    @(negedge clk); @(negedge clk);
    rst = 0;
    for (int k = 0; k < 3; k++) lastMem[k] = 1'b0;
  endtask

  task automatic preload();
    for (int i = 0; i < 64; i++) begin
      plEn = 1; plAddr = 6'(i);
      plData = (i == 'h12) ? 16'hBEEF : 16'($urandom);
      refMem[i] = plData;
      @(negedge clk);
    end
    plEn = 0;
  endtask

  task automatic waitAck(input bit isIf, input bit scramble, output int n, output bit otherSeen,
                         output bit stallBad);
    bit ack, oth, st;
    n = 0; otherSeen = 0; stallBad = 0; ack = 0;
    while (!ack && n < 40) begin
      @(negedge clk);
      n++;
      if (scramble && n == 1) begin
        if_addr = 18'($urandom); mem_addr = 18'($urandom); mem_wdata = 16'($urandom);
      end
      ack = isIf ? ifAck[sel] : memAck[sel];
      oth = isIf ? memAck[sel] : ifAck[sel];
      st  = isIf ? ifStall[sel] : memStall[sel];
      if (oth) otherSeen = 1;
      if (st !== !ack) stallBad = 1;
    end
  endtask

  task automatic test_reset();
    rst = 1;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      total++;
      if ({enN[k], oeN[k], weN[k]} !== 3'b111) begin
        bad++; $display("[TB] FAIL reset_ctrl dut=%0d got=%b exp=111", k, {enN[k], oeN[k], weN[k]});
      end
      total++;
      if (sAddr[k] !== '0) begin bad++; $display("[TB] FAIL reset_addr dut=%0d got=%h exp=0", k, sAddr[k]); end
      total++;
      if ({ifAck[k], memAck[k]} !== 2'b00) begin
        bad++; $display("[TB] FAIL reset_ack dut=%0d got=%b exp=00", k, {ifAck[k], memAck[k]});
      end
      total++;
      if (ifRdata[k] !== '0 || memRdata[k] !== '0) begin
        bad++; $display("[TB] FAIL reset_rdata dut=%0d got=%h/%h exp=0/0", k, ifRdata[k], memRdata[k]);
      end
    end
    rst = 0;
    for (int k = 0; k < 3; k++) lastMem[k] = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_mem_read();
    int w;
    bit expOe, expAck;
    sel = 0; w = waitOf(sel);
    mem_addr = 18'h00012; mem_we = 0; mem_req = 1;
    for (int c = 1; c <= w + 3; c++) begin
      @(negedge clk);
      expOe = !(c <= w + 1);
      expAck = (c == w + 2);
      total++;
      if ({enN[sel], oeN[sel], weN[sel]} !== {expOe, expOe, 1'b1}) begin
        bad++; $display("[TB] FAIL t1_ctrl c=%0d got=%b exp=%b", c, {enN[sel], oeN[sel], weN[sel]}, {expOe, expOe, 1'b1});
      end
      total++;
      if (memAck[sel] !== expAck || ifAck[sel] !== 1'b0) begin
        bad++; $display("[TB] FAIL t1_ack c=%0d got=%b%b exp=%b0", c, memAck[sel], ifAck[sel], expAck);
      end
      if (c == 1) begin
        total++;
        if (sAddr[sel] !== 18'h00012) begin bad++; $display("[TB] FAIL t1_addr got=%h exp=00012", sAddr[sel]); end
      end
      if (expAck) begin
        total++;
        if (memRdata[sel] !== refMem['h12]) begin
          bad++; $display("[TB] FAIL t1_data got=%h exp=%h", memRdata[sel], refMem['h12]);
        end
        mem_req = 0;
      end
    end
  endtask

  task automatic test_mem_write();
    int w, n;
    bit expWe, expEn, expAck, oth, sb;
    sel = 0; w = waitOf(sel);
    mem_addr = 18'h00034; mem_wdata = 16'h1234; mem_we = 1; mem_req = 1;
    for (int c = 1; c <= w + 4; c++) begin
      @(negedge clk);
      expWe = !(c <= w + 1);
      expEn = !(c <= w + 2);
      expAck = (c == w + 3);
      total++;
      if ({enN[sel], oeN[sel], weN[sel]} !== {expEn, 1'b1, expWe}) begin
        bad++; $display("[TB] FAIL t2_ctrl c=%0d got=%b exp=%b", c, {enN[sel], oeN[sel], weN[sel]}, {expEn, 1'b1, expWe});
      end
      total++;
      if (memAck[sel] !== expAck) begin bad++; $display("[TB] FAIL t2_ack c=%0d got=%b exp=%b", c, memAck[sel], expAck); end
      if (c == 1 || c == w + 2) begin
        total++;
        if (busObs[sel] !== 16'h1234) begin bad++; $display("[TB] FAIL t2_bus c=%0d got=%h exp=1234", c, busObs[sel]); end
      end
      if (expAck) begin mem_req = 0; refMem['h34] = 16'h1234; end
    end
    mem_we = 0; mem_req = 1;
    waitAck(0, 0, n, oth, sb);
    mem_req = 0;
    total++;
    if (n !== w + 2) begin bad++; $display("[TB] FAIL t2_rb_lat got=%0d exp=%0d", n, w + 2); end
    total++;
    if (memRdata[sel] !== 16'h1234) begin bad++; $display("[TB] FAIL t2_rb_data got=%h exp=1234", memRdata[sel]); end
    @(negedge clk);
  endtask

  task automatic test_arbitration();
    int w, c, gotIf, gotMem, cnt;
    bit both, expMem;
    logic [AW-1:0] ia, ma;
    sel = 0; w = waitOf(sel);
    ia = 18'($urandom); ma = 18'($urandom);
    if_addr = ia; mem_addr = ma; mem_we = 0; if_req = 1; mem_req = 1;
    gotIf = -1; gotMem = -1; both = 0; c = 0;
    while ((if_req || mem_req) && c < 40) begin
      @(negedge clk); c++;
      if (ifAck[sel] && memAck[sel]) both = 1;
      if (ifAck[sel]) begin
        gotIf = c; if_req = 0;
        total++;
        if (ifRdata[sel] !== refMem[ia[5:0]]) begin bad++; $display("[TB] FAIL t3_ifdata got=%h exp=%h", ifRdata[sel], refMem[ia[5:0]]); end
      end
      if (memAck[sel]) begin gotMem = c; mem_req = 0; end
    end
    total++;
    if (gotMem !== w + 2) begin bad++; $display("[TB] FAIL t3_mem_first got=%0d exp=%0d", gotMem, w + 2); end
    total++;
    if (gotIf !== 2 * w + 4) begin bad++; $display("[TB] FAIL t3_if_second got=%0d exp=%0d", gotIf, 2 * w + 4); end
    total++;
    if (both !== 1'b0) begin bad++; $display("[TB] FAIL t3_dual_ack got=%b exp=0", both); end
    if_req = 0; mem_req = 0;
    @(negedge clk);

    doReset();
    sel = 1;
    ia = 18'($urandom); ma = 18'($urandom);
    if_addr = ia; mem_addr = ma; mem_we = 0; if_req = 1; mem_req = 1;
    expMem = !lastMem[sel]; cnt = 0; c = 0;
    while (cnt < 4 && c < 60) begin
      @(negedge clk); c++;
      if (ifAck[sel] || memAck[sel]) begin
        total++;
        if (memAck[sel] !== expMem || ifAck[sel] !== !expMem) begin
          bad++; $display("[TB] FAIL t3_fair_order n=%0d got=mem%b/if%b exp_mem=%b", cnt, memAck[sel], ifAck[sel], expMem);
        end
        if (ifAck[sel]) begin
          total++;
          if (ifRdata[sel] !== refMem[ia[5:0]]) begin bad++; $display("[TB] FAIL t3_fair_ifdata got=%h exp=%h", ifRdata[sel], refMem[ia[5:0]]); end
          ia = 18'($urandom); if_addr = ia;
        end
        if (memAck[sel]) begin
          total++;
          if (memRdata[sel] !== refMem[ma[5:0]]) begin bad++; $display("[TB] FAIL t3_fair_memdata got=%h exp=%h", memRdata[sel], refMem[ma[5:0]]); end
          ma = 18'($urandom); mem_addr = ma;
        end
        lastMem[sel] = expMem;
        expMem = !expMem;
        cnt++;
        if (cnt == 4) begin if_req = 0; mem_req = 0; end
      end
    end
    if_req = 0; mem_req = 0;
    total++;
    if (cnt !== 4) begin bad++; $display("[TB] FAIL t3_fair_count got=%0d exp=4", cnt); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int w, n, ackSeen;
    bit oth, sb;
    logic [AW-1:0] a;
    sel = 0; w = waitOf(sel);
    mem_addr = 18'($urandom); mem_we = 0; mem_req = 1;
    @(negedge clk);
    @(posedge clk);
    #2 rst = 1;
    #1;
    total++;
    if ({enN[sel], oeN[sel]} !== 2'b11) begin bad++; $display("[TB] FAIL t4_async got=%b exp=11", {enN[sel], oeN[sel]}); end
    mem_req = 0;
    @(negedge clk); @(negedge clk);
    rst = 0;
    for (int k = 0; k < 3; k++) lastMem[k] = 1'b0;
    ackSeen = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (ifAck[sel] || memAck[sel]) ackSeen++;
    end
    total++;
    if (ackSeen !== 0) begin bad++; $display("[TB] FAIL t4_no_ack got=%0d exp=0", ackSeen); end
    a = 18'($urandom);
    mem_addr = a; mem_req = 1;
    waitAck(0, 0, n, oth, sb);
    mem_req = 0;
    total++;
    if (n !== w + 2) begin bad++; $display("[TB] FAIL t4_after_lat got=%0d exp=%0d", n, w + 2); end
    total++;
    if (memRdata[sel] !== refMem[a[5:0]]) begin bad++; $display("[TB] FAIL t4_after_data got=%h exp=%h", memRdata[sel], refMem[a[5:0]]); end
    @(negedge clk);
  endtask

  task automatic test_if_stream();
    int w, k;
    bit expAck;
    sel = 2; w = waitOf(sel);
    k = 0; if_addr = '0; if_req = 1;
    for (int c = 1; c <= (w + 2) + 2 * (w + 3); c++) begin
      @(negedge clk);
      expAck = (c >= w + 2) && (((c - (w + 2)) % (w + 3)) == 0);
      total++;
      if (ifAck[sel] !== expAck) begin bad++; $display("[TB] FAIL t5_ack c=%0d got=%b exp=%b", c, ifAck[sel], expAck); end
      total++;
      if (ifStall[sel] !== !expAck) begin bad++; $display("[TB] FAIL t5_stall c=%0d got=%b exp=%b", c, ifStall[sel], !expAck); end
      if (ifAck[sel]) begin
        total++;
        if (ifRdata[sel] !== refMem[k]) begin bad++; $display("[TB] FAIL t5_data k=%0d got=%h exp=%h", k, ifRdata[sel], refMem[k]); end
        k++;
        if_addr = 18'(k);
        if (k == 3) if_req = 0;
      end
    end
    if_req = 0;
    @(negedge clk);
  endtask

  task automatic test_drop_req();
    int w, acks, enLow;
    logic [AW-1:0] a;
    sel = 0; w = waitOf(sel);
    a = 18'($urandom);
    mem_addr = a; mem_we = 0; mem_req = 1;
    acks = 0; enLow = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 1) mem_req = 0;
      if (!enN[sel]) enLow++;
      if (memAck[sel]) begin
        acks++;
        total++;
        if (memRdata[sel] !== refMem[a[5:0]]) begin bad++; $display("[TB] FAIL t6_data got=%h exp=%h", memRdata[sel], refMem[a[5:0]]); end
      end
    end
    total++;
    if (acks !== 1) begin bad++; $display("[TB] FAIL t6_acks got=%0d exp=1", acks); end
    total++;
    if (enLow !== w + 1) begin bad++; $display("[TB] FAIL t6_en_cycles got=%0d exp=%0d", enLow, w + 1); end
  endtask

  task automatic test_random();
    int w, kind, n, expN;
    bit oth, sb;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    for (int it = 0; it < 40; it++) begin
      sel = $urandom_range(0, 2); w = waitOf(sel);
      kind = $urandom_range(0, 2);
      a = 18'($urandom); d = 16'($urandom);
      if (kind == 0) begin if_addr = a; if_req = 1; end
      else begin mem_addr = a; mem_we = (kind == 2); mem_wdata = d; mem_req = 1; end
      waitAck(kind == 0, 1'($urandom_range(0, 1)), n, oth, sb);
      expN = (kind == 2) ? w + 3 : w + 2;
      total++;
      if (n !== expN) begin bad++; $display("[TB] FAIL rnd_lat it=%0d kind=%0d got=%0d exp=%0d", it, kind, n, expN); end
      total++;
      if (oth !== 1'b0 || sb !== 1'b0) begin bad++; $display("[TB] FAIL rnd_side it=%0d got=oth%b/stall%b exp=0/0", it, oth, sb); end
      if (kind == 0) begin
        total++;
        if (ifRdata[sel] !== refMem[a[5:0]]) begin bad++; $display("[TB] FAIL rnd_ifdata it=%0d got=%h exp=%h", it, ifRdata[sel], refMem[a[5:0]]); end
      end else if (kind == 1) begin
        total++;
        if (memRdata[sel] !== refMem[a[5:0]]) begin bad++; $display("[TB] FAIL rnd_memdata it=%0d got=%h exp=%h", it, memRdata[sel], refMem[a[5:0]]); end
      end else begin
        refMem[a[5:0]] = d;
      end
      lastMem[sel] = (kind != 0);
      if_req = 0; mem_req = 0;
      @(negedge clk);
    end
  endtask

  task automatic test_contention();
    int w, pat, lIf, lMem, expIf, expMemC, gotIf, gotMem, c;
    bit wantIf, wantMem, we, firstMem, both;
    logic [AW-1:0] ia, ma;
    logic [DW-1:0] md;
    for (int r = 0; r < 30; r++) begin
      sel = $urandom_range(0, 1); w = waitOf(sel);
      pat = $urandom_range(1, 3);
      wantIf = pat[0]; wantMem = pat[1]; we = 1'($urandom_range(0, 1));
      ia = 18'($urandom); ma = 18'($urandom); md = 16'($urandom);
      firstMem = wantMem && (!wantIf || !fairOf(sel) || !lastMem[sel]);
      lIf = w + 2; lMem = we ? w + 3 : w + 2;
      expMemC = !wantMem ? -1 : (firstMem ? lMem : lIf + lMem);
      expIf = !wantIf ? -1 : (!firstMem ? lIf : lMem + lIf);
      if_addr = ia; mem_addr = ma; mem_we = we; mem_wdata = md;
      if_req = wantIf; mem_req = wantMem;
      gotIf = -1; gotMem = -1; both = 0; c = 0;
      while ((if_req || mem_req) && c < 40) begin
        @(negedge clk); c++;
        if (ifAck[sel] && memAck[sel]) both = 1;
        if (ifAck[sel] && if_req) begin
          gotIf = c; if_req = 0;
          total++;
          if (ifRdata[sel] !== refMem[ia[5:0]]) begin bad++; $display("[TB] FAIL cnt_ifdata r=%0d got=%h exp=%h", r, ifRdata[sel], refMem[ia[5:0]]); end
        end
        if (memAck[sel] && mem_req) begin
          gotMem = c; mem_req = 0;
          if (we) refMem[ma[5:0]] = md;
          else begin
            total++;
            if (memRdata[sel] !== refMem[ma[5:0]]) begin bad++; $display("[TB] FAIL cnt_memdata r=%0d got=%h exp=%h", r, memRdata[sel], refMem[ma[5:0]]); end
          end
        end
      end
      if_req = 0; mem_req = 0;
      lastMem[sel] = (wantIf && wantMem) ? !firstMem : wantMem;
      total++;
      if (gotIf !== expIf) begin bad++; $display("[TB] FAIL cnt_if_cycle r=%0d dut=%0d got=%0d exp=%0d", r, sel, gotIf, expIf); end
      total++;
      if (gotMem !== expMemC) begin bad++; $display("[TB] FAIL cnt_mem_cycle r=%0d dut=%0d got=%0d exp=%0d", r, sel, gotMem, expMemC); end
      total++;
      if (both !== 1'b0) begin bad++; $display("[TB] FAIL cnt_dual_ack r=%0d got=%b exp=0", r, both); end
      @(negedge clk);
    end
  endtask

  initial begin
    rst = 1; sel = 0; plEn = 0; plAddr = '0; plData = '0;
    if_req = 0; mem_req = 0; mem_we = 0;
    if_addr = '0; mem_addr = '0; mem_wdata = '0;
    test_reset();
    preload();
    test_mem_read();
    test_mem_write();
    test_arbitration();
    test_reset_mid();
    test_if_stream();
    test_drop_req();
    test_random();
    test_contention();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
